// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute controller for the 8-bit processor.
// Ports:
//   ctrl_main_clk, ctrl_main_rst_n   clock, synchronous active-low reset
//   ctrl_run                         start request (IDLE/HALT/FAULT only)
//   ctrl_mem_data, ctrl_mem_valid    instruction word from program memory
//   ctrl_pc_rst/incr/decr/out_en     program counter controls
//   ctrl_mem_rd                      memory read request
//   ctrl_acc_load, ctrl_alu_en,
//   ctrl_alu_op, ctrl_out_load       one-cycle datapath strobes
//   ctrl_operand                     IR[4:0]
//   ctrl_halted, ctrl_fault,
//   ctrl_state                       status
`timescale 1ns/1ps
module pc_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 8
) (
    input  logic       ctrl_main_clk,
    input  logic       ctrl_main_rst_n,
    input  logic       ctrl_run,
    input  logic [7:0] ctrl_mem_data,
    input  logic       ctrl_mem_valid,
    output logic       ctrl_pc_rst,
    output logic       ctrl_pc_incr,
    output logic       ctrl_pc_decr,
    output logic       ctrl_pc_out_en,
    output logic       ctrl_mem_rd,
    output logic       ctrl_acc_load,
    output logic       ctrl_alu_en,
    output logic [1:0] ctrl_alu_op,
    output logic       ctrl_out_load,
    output logic [4:0] ctrl_operand,
    output logic       ctrl_halted,
    output logic       ctrl_fault,
    output logic [2:0] ctrl_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        READ   = 3'd2,
        DECODE = 3'd3,
        EXEC   = 3'd4,
        REWIND = 3'd5,
        HALT   = 3'd6,
        FAULT  = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [2:0] shadow_q, shadow_d;
    logic [2:0] rem_q, rem_d;
    logic [3:0] tmo_q, tmo_d;
    logic [2:0] opcode;
    logic       advance;
    logic       at_end;
    logic       decr;

    assign opcode  = ir_q[7:5];
    // Opcodes that fall through to the next address; BACK 0 behaves like a NOP.
    assign advance = (opcode <= 3'd4) || (opcode == 3'd5 && ir_q[2:0] == 3'd0);
    // The 3-bit PC must never wrap, so the last address ends the program.
    assign at_end  = shadow_q == 3'd7;
    assign decr    = state_q == REWIND && rem_q != 3'd0 && shadow_q != 3'd0;

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        shadow_d = shadow_q;
        rem_d    = rem_q;
        tmo_d    = tmo_q;
        case (state_q)
            IDLE: begin
                shadow_d = 3'd0;
                state_d  = ctrl_run ? ADDR : IDLE;
            end
            ADDR: begin
                tmo_d   = 4'd0;
                state_d = READ;
            end
            READ: begin
                if (ctrl_mem_valid) begin
                    ir_d    = ctrl_mem_data;
                    state_d = DECODE;
                end else if (tmo_q == 4'(MEM_TIMEOUT - 1)) begin
                    state_d = FAULT;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                if (opcode == 3'd6) begin
                    state_d = FAULT;
                end else if (opcode == 3'd7) begin
                    state_d = HALT;
                end else if (!advance) begin
                    rem_d   = ir_q[2:0];
                    state_d = REWIND;
                end else if (at_end) begin
                    state_d = HALT;
                end else begin
                    shadow_d = shadow_q + 3'd1;
                    state_d  = ADDR;
                end
            end
            REWIND: begin
                // Stepping back stops early at address 0, landing at max(a-n, 0).
                if (decr) begin
                    shadow_d = shadow_q - 3'd1;
                    rem_d    = rem_q - 3'd1;
                end else begin
                    state_d = ADDR;
                end
            end
            default: state_d = ctrl_run ? state_q : IDLE;
        endcase
    end

    always_ff @(posedge ctrl_main_clk) begin
        if (!ctrl_main_rst_n) begin
            state_q  <= IDLE;
            ir_q     <= 8'd0;
            shadow_q <= 3'd0;
            rem_q    <= 3'd0;
            tmo_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            shadow_q <= shadow_d;
            rem_q    <= rem_d;
            tmo_q    <= tmo_d;
        end
    end

    assign ctrl_pc_rst    = state_q == IDLE;
    assign ctrl_pc_out_en = state_q == ADDR || state_q == READ;
    assign ctrl_mem_rd    = state_q == READ;
    assign ctrl_pc_incr   = state_q == EXEC && advance && !at_end;
    assign ctrl_pc_decr   = decr;
    assign ctrl_acc_load  = state_q == EXEC && opcode == 3'd1;
    assign ctrl_alu_en    = state_q == EXEC && (opcode == 3'd2 || opcode == 3'd3);
    assign ctrl_alu_op    = (state_q == EXEC && opcode == 3'd3) ? 2'b01 : 2'b00;
    assign ctrl_out_load  = state_q == EXEC && opcode == 3'd4;
    assign ctrl_operand   = ir_q[4:0];
    assign ctrl_halted    = state_q == HALT;
    assign ctrl_fault     = state_q == FAULT;
    assign ctrl_state     = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer with a PC and memory model.
`timescale 1ns/1ps
module tb_pc_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] mem_data = 8'hFF;
    logic       mem_valid = 1'b0;
    logic       pc_rst, pc_incr, pc_decr, pc_out_en, mem_rd;
    logic       acc_load, alu_en, out_load, halted, fault;
    logic [1:0] alu_op;
    logic [4:0] operand;
    logic [2:0] state;

    localparam logic [8:0] ACC = 9'h100, ALU = 9'h080, SUBOP = 9'h020, OUTL = 9'h010;
    localparam logic [8:0] INC = 9'h008, DEC = 9'h004, HLT = 9'h002, FLT = 9'h001;
    localparam logic [2:0] S_IDLE = 3'd0, S_READ = 3'd2, S_EXEC = 3'd4, S_REW = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6, S_FAULT = 3'd7;

    always #5 clk = ~clk;

    pc_sequencer #(.MEM_TIMEOUT(8)) dut (
        .ctrl_main_clk(clk), .ctrl_main_rst_n(rst_n), .ctrl_run(run),
        .ctrl_mem_data(mem_data), .ctrl_mem_valid(mem_valid),
        .ctrl_pc_rst(pc_rst), .ctrl_pc_incr(pc_incr), .ctrl_pc_decr(pc_decr),
        .ctrl_pc_out_en(pc_out_en), .ctrl_mem_rd(mem_rd), .ctrl_acc_load(acc_load),
        .ctrl_alu_en(alu_en), .ctrl_alu_op(alu_op), .ctrl_out_load(out_load),
        .ctrl_operand(operand), .ctrl_halted(halted), .ctrl_fault(fault),
        .ctrl_state(state)
    );

    int          cyc = 0, t0 = 0, errors = 0, checks = 0;
    logic [2:0]  pc = 3'd0;
    logic [7:0]  prog[$];
    int          lat = 0, idx = 0, rd_cnt = 0;
    bit          dead = 1'b0;
    logic [25:0] expq[$];

    // Physical PC the sequencer controls.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        pc  <= pc_rst ? 3'd0 : pc_incr ? pc + 3'd1 : pc_decr ? pc - 3'd1 : pc;
    end

    // Program memory: serves the instruction stream in fetch order after lat wait cycles.
    initial forever begin
        @(negedge clk);
        if (mem_rd) begin
            mem_valid = !dead && rd_cnt >= lat && idx < prog.size();
            mem_data  = mem_valid ? prog[idx] : 8'h00;
            if (mem_valid) idx++;
            rd_cnt++;
        end else begin
            mem_valid = 1'b0;
            mem_data  = 8'hFF;
            rd_cnt    = 0;
            if (state == S_IDLE) idx = 0;
        end
    end

    // Monitor: every strobe cycle and every entry into HALT/FAULT is one event.
    initial begin
        logic hp, fp, ev;
        logic [25:0] act, e;
        hp = 1'b0;
        fp = 1'b0;
        forever begin
            @(negedge clk);
            ev = acc_load | alu_en | (alu_op != 2'b00) | out_load | pc_incr | pc_decr |
                 (halted & !hp) | (fault & !fp);
            hp = halted;
            fp = fault;
            if (ev) begin
                act = {6'(cyc - t0), state, acc_load, alu_en, alu_op, out_load, pc_incr,
                       pc_decr, halted, fault, operand, pc};
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL event: unexpected %h, none required", act);
                end else begin
                    e = expq.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL event: got %h required %h", act, e);
                    end
                end
            end
        end
    end

    function automatic logic [25:0] rec(input int st, input logic [2:0] s, input logic [8:0] fl,
                                        input logic [4:0] opd, input logic [2:0] p);
        return {6'(st), s, fl, opd, p};
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim);
        int n = 0;
        while (state !== s && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state", int'(state), int'(s));
    endtask

    task automatic start(input int l, input bit d);
        lat  = l;
        dead = d;
        @(negedge clk);
        run = 1'b1;
        t0  = cyc;
    endtask

    task automatic finish_prog(input logic [2:0] s);
        wait_state(s, 100);
        run = 1'b0;
        wait_state(S_IDLE, 4);
        chk("idle_pc_rst", int'(pc_rst), 1);
        chk("drain", expq.size(), 0);
    endtask

    function automatic int outv();
        return int'({pc_rst, pc_incr, pc_decr, pc_out_en, mem_rd, acc_load, alu_en, alu_op,
                     out_load, operand, halted, fault, state});
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", outv(), 32'h80000);
        rst_n = 1'b1;

        // LDA 5, ADD 3, OUT, HALT
        prog = '{8'h25, 8'h43, 8'h80, 8'hE0};
        expq.push_back(rec(4, S_EXEC, ACC | INC, 5'd5, 3'd0));
        expq.push_back(rec(8, S_EXEC, ALU | INC, 5'd3, 3'd1));
        expq.push_back(rec(12, S_EXEC, OUTL | INC, 5'd0, 3'd2));
        expq.push_back(rec(17, S_HALT, HLT, 5'd0, 3'd3));
        start(0, 1'b0);
        finish_prog(S_HALT);

        // Eight NOPs: no increment at address 7
        prog = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 7; i++) expq.push_back(rec(4 + 4 * i, S_EXEC, INC, 5'd0, 3'(i)));
        expq.push_back(rec(33, S_HALT, HLT, 5'd0, 3'd7));
        start(0, 1'b0);
        finish_prog(S_HALT);

        // SUB 6, then BACK 5 at address 2: two decrements, lands at 0
        prog = '{8'h66, 8'h00, 8'hA5, 8'hE0};
        expq.push_back(rec(4, S_EXEC, ALU | SUBOP | INC, 5'd6, 3'd0));
        expq.push_back(rec(8, S_EXEC, INC, 5'd0, 3'd1));
        expq.push_back(rec(13, S_REW, DEC, 5'd5, 3'd2));
        expq.push_back(rec(14, S_REW, DEC, 5'd5, 3'd1));
        expq.push_back(rec(20, S_HALT, HLT, 5'd0, 3'd0));
        start(0, 1'b0);
        finish_prog(S_HALT);

        // BACK 2 at address 4: lands at 2 after one idle REWIND cycle
        prog = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA2, 8'hE0};
        for (int i = 0; i < 4; i++) expq.push_back(rec(4 + 4 * i, S_EXEC, INC, 5'd0, 3'(i)));
        expq.push_back(rec(21, S_REW, DEC, 5'd2, 3'd4));
        expq.push_back(rec(22, S_REW, DEC, 5'd2, 3'd3));
        expq.push_back(rec(28, S_HALT, HLT, 5'd0, 3'd2));
        start(0, 1'b0);
        finish_prog(S_HALT);

        // Memory never answers: FAULT after 8 READ cycles
        expq.push_back(rec(10, S_FAULT, FLT, 5'd0, 3'd0));
        start(0, 1'b1);
        finish_prog(S_FAULT);

        // Reserved opcode 110: FAULT, no strobes, PC untouched
        prog = '{8'hC7};
        expq.push_back(rec(5, S_FAULT, FLT, 5'd7, 3'd0));
        start(0, 1'b0);
        finish_prog(S_FAULT);

        // Two READ wait cycles per fetch
        prog = '{8'h29, 8'hE0};
        expq.push_back(rec(6, S_EXEC, ACC | INC, 5'd9, 3'd0));
        expq.push_back(rec(13, S_HALT, HLT, 5'd0, 3'd1));
        start(2, 1'b0);
        finish_prog(S_HALT);

        // Valid in the last READ cycle before timeout still fetches
        prog = '{8'hE0};
        expq.push_back(rec(12, S_HALT, HLT, 5'd0, 3'd0));
        start(7, 1'b0);
        finish_prog(S_HALT);

        // Reset during READ, then refetch from address 0
        start(0, 1'b1);
        wait_state(S_READ, 10);
        rst_n = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        chk("rst_in_read", outv(), 32'h80000);
        rst_n = 1'b1;
        prog  = '{8'hE0};
        expq.push_back(rec(5, S_HALT, HLT, 5'd0, 3'd0));
        start(0, 1'b0);
        finish_prog(S_HALT);

        // Reset during REWIND
        prog = '{8'h00, 8'h00, 8'hA5};
        expq.push_back(rec(4, S_EXEC, INC, 5'd0, 3'd0));
        expq.push_back(rec(8, S_EXEC, INC, 5'd0, 3'd1));
        expq.push_back(rec(13, S_REW, DEC, 5'd5, 3'd2));
        start(0, 1'b0);
        wait_state(S_REW, 30);
        rst_n = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        chk("rst_in_rewind", outv(), 32'h80000);
        @(negedge clk);
        chk("pc_after_reset", int'(pc), 0);
        rst_n = 1'b1;
        prog  = '{8'h25, 8'hE0};
        expq.push_back(rec(4, S_EXEC, ACC | INC, 5'd5, 3'd0));
        expq.push_back(rec(9, S_HALT, HLT, 5'd0, 3'd1));
        start(0, 1'b0);
        finish_prog(S_HALT);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
